// File: rtl/dsp_pipe_stage.sv
// rtl/dsp_pipe_stage.sv - elastic multi-stage DSP pipeline register with backpressure, ce and flush
// DEPTH=0 degenerates to a combinational pass-through with no state.
module dsp_pipe_stage #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 2,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             sclr,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] occ
);

  if (DEPTH == 0) begin : g_pass
    logic unused_pass;
    assign unused_pass = ^{clk, rst};
    assign out_data    = in_data;
    assign out_valid   = ce & ~sclr & in_valid;
    assign in_ready    = ce & ~sclr & out_ready;
    assign occ         = '0;
  end else begin : g_pipe
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] v_q, v_d;
    logic [DEPTH-1:0] acc;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic             run, in_fire, out_fire;

    assign run = ce & ~sclr;

    // acc ripples from the output back to stage 0, so an empty stage
    // anywhere downstream lets upstream words collapse into it.
    always_comb begin
      logic go;
      go  = out_ready;
      acc = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        acc[k] = ~v_q[k] | go;
        go     = acc[k];
      end
    end

    assign in_ready  = rst & run & acc[0];
    assign out_valid = run & v_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign occ       = occ_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
      logic [WIDTH-1:0] src_data;
      logic             src_v;
      v_d      = v_q;
      data_d   = data_q;
      occ_d    = occ_q;
      src_data = in_data;
      src_v    = in_fire;
      if (sclr) begin
        v_d   = '0;
        occ_d = '0;
        for (int k = 0; k < DEPTH; k++) data_d[k] = '0;
      end else if (ce) begin
        occ_d = occ_q + CNT_W'(in_fire) - CNT_W'(out_fire);
        for (int k = 0; k < DEPTH; k++) begin
          // an emptied stage keeps its stale data; only its valid bit drops
          if (acc[k]) begin
            data_d[k] = src_data;
            v_d[k]    = src_v;
          end
          src_data = data_q[k];
          src_v    = v_q[k];
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        v_q   <= '0;
        occ_q <= '0;
        for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
      end else begin
        v_q    <= v_d;
        occ_q  <= occ_d;
        data_q <= data_d;
      end
    end
  end

endmodule

// File: doc/dsp_pipe_stage.md
# dsp_pipe_stage

Parametrised elastic pipeline register for the DSP48A1 datapath: a chain of DEPTH data stages with per-stage valid bits, ready/valid backpressure with bubble collapse, global clock enable, and synchronous flush. It generalises the single-stage optional register used on the A/B/C/D/M/P paths to a multi-stage, stall-aware delay line. It is used wherever a DSP operand or result path needs more than one register level, or must tolerate a stalled consumer.

## Interface
- WIDTH, 18, data width in bits (1..64)
- DEPTH, 2, number of register stages (0..8); 0 = combinational pass-through
- CNT_W, 4, width of occ; must be ≥ $clog2(DEPTH+1)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low; clears all stages
- ce  in  1  clock enable; 0 freezes every stage
- sclr  in  1  synchronous flush, active-high
- in_data  in  WIDTH  upstream data
- in_valid  in  1  upstream data valid
- in_ready  out  1  stage 0 can accept this cycle
- out_data  out  WIDTH  data of last stage
- out_valid  out  1  last stage holds valid data
- out_ready  in  1  downstream accepts
- occ  out  CNT_W  number of valid stages (0..DEPTH)

## Operation
- State: data[k] (WIDTH bits) and v[k] for k = 0..DEPTH-1; stage DEPTH-1 drives the output.
- Reset (rst=0, async): all v[k]=0, all data[k]=0, occ=0. Outputs: in_ready=0, out_valid=0, out_data=0.
- The stage's ability to move out is:
  - go[DEPTH-1] = out_ready.
  - go[k] = acc[k+1] for k < DEPTH-1.
- A stage accepts when acc[k] = ~v[k] | go[k]. This gives bubble collapse: an empty stage accepts even when everything downstream is stalled.
- in_ready = ce & ~sclr & acc[0]. out_valid = ce & ~sclr & v[DEPTH-1].
- Transfers:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Per edge, when ce=1 and sclr=0, for each stage k with acc[k]=1:
  - data[k] ← previous-stage data. The source is in_data for k=0.
  - v[k] ← previous-stage valid. The source is in_fire for k=0.
  - Stages with acc[k]=0 hold data and valid.
  - A stage that empties without being refilled keeps its stale data; only v[k] is cleared.
- ce=0: no state changes. in_ready=0 and out_valid=0, so no handshake completes.
- sclr=1 (priority over ce): every v[k] and data[k] is set to 0 at the edge. No in_fire or out_fire occurs in that cycle.
- occ = popcount(v). It is registered and updated with the stages; occ_next = occ + in_fire − out_fire.
- DEPTH=0 (combinational pass-through):
  - out_data = in_data.
  - out_valid = ce & ~sclr & in_valid.
  - in_ready = ce & ~sclr & out_ready.
  - occ = 0; no registers.
- Data is never modified; the arithmetic is width-preserving.

## Timing
- Latency through an empty, unstalled pipe: a word accepted at edge n appears on out_data/out_valid after edge n+DEPTH−1, i.e. DEPTH cycles from in_fire to out_valid. Throughput is 1 word/cycle.
- in_ready depends combinationally on out_ready through the acc chain, with no registered skid. Full rate is sustained when the pipe is full and out_ready=1.
- Full pipe (occ=DEPTH) with out_ready=0: in_ready=0 and all stages hold.
- Releasing out_ready on a full pipe: in_ready=1 in the same cycle and occ stays DEPTH.
- Simultaneous in_fire and out_fire: occ is unchanged.
- Reset asserted mid-stream: all valid data is lost immediately (async). The first in_ready=1 is in the first cycle after release with ce=1.
- sclr and in_valid in the same cycle: the input word is dropped (in_ready=0).

## Test plan
- Reset/latency, DEPTH=3, WIDTH=18: release rst; drive 0x00001,0x00002,0x00003 with in_valid=1 and out_ready=1 → out_valid rises 3 cycles after the first in_fire; out_data sequence is 1,2,3; occ reaches 3.
- Backpressure/bubble collapse, DEPTH=3: load one word 0x0AAAA, then hold out_ready=0 → the word advances to stage 2 with occ=1. Push 0x0BBBB,0x0CCCC → occ=3 and in_ready=0. Raise out_ready → 0x0AAAA,0x0BBBB,0x0CCCC emerge in order with no loss or duplication.
- Clock enable: mid-stream with occ=2, hold ce=0 for 4 cycles while in_valid=1 → no state change, in_ready=0, out_valid=0. Restore ce → the stream resumes with identical ordering.
- Flush: with occ=3 (DEPTH=3), assert sclr for one cycle with in_valid=1 → next cycle occ=0 and out_valid=0, the input word is dropped, and data regs read 0.
- Async reset mid-transfer: drop rst between edges with occ=2 → out_valid and occ go to 0 immediately, without waiting for an edge.
- DEPTH=0: toggle in_valid and out_ready randomly for 50 cycles → out_data==in_data, out_valid==in_valid&ce, in_ready==out_ready&ce, occ==0 every cycle.
